// File: rtl/ram_pattern_checker.sv
// Read-side RAM pattern checker: sweeps the RAM with an odd stride and compares each
// word against seed + addr (mod 256), reporting pass/fail, error count and first bad address.
module ram_pattern_checker #(
   parameter  int DEPTH  = 4,
   parameter  int STRIDE = 3,
   localparam int AW     = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [7:0]    seed,
   output logic          rd_en,
   output logic [AW-1:0] rd_addr,
   input  logic [7:0]    rd_data,
   output logic          busy,
   output logic          done,
   output logic          pass,
   output logic [AW:0]   err_count,
   output logic [AW-1:0] first_err_addr,
   output logic [7:0]    led
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_FIN
   } state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic [7:0]    seed_q, seed_d;
   logic          pass_q, pass_d;
   logic [AW:0]   err_q, err_d;
   logic [AW-1:0] first_q, first_d;
   logic [7:0]    led_q, led_d;
   logic          cmp_vld_q;
   logic [AW-1:0] cmp_addr_q;

   logic          accept;
   logic          mismatch;
   logic [7:0]    expected;

   always_comb begin
      // NOTE: every variable gets a default before any branch so no latch can be inferred.
      state_d = state_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      seed_d  = seed_q;
      pass_d  = pass_q;
      err_d   = err_q;
      first_d = first_q;
      led_d   = led_q;

      expected = seed_q + 8'(cmp_addr_q);
      mismatch = cmp_vld_q && (rd_data != expected);
      accept   = start && ((state_q == S_IDLE) || (state_q == S_FIN));

      if (cmp_vld_q) begin
         led_d = rd_data;
      end
      if (mismatch) begin
         err_d = err_q + 1'b1;
         if (err_q == '0) begin
            first_d = cmp_addr_q;
         end
      end

      case (state_q)
         S_IDLE: ;
         S_RUN: begin
            if (cnt_q == AW'(DEPTH - 1)) begin
               state_d = S_DRAIN;
            end else begin
               cnt_d  = cnt_q + 1'b1;
               addr_d = addr_q + AW'(STRIDE);
            end
         end
         // err_d already includes the last compare, so the verdict is final here.
         S_DRAIN: begin
            state_d = S_FIN;
            pass_d  = (err_d == '0);
         end
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // A start in FIN chains straight into the next pass.
      if (accept) begin
         state_d = S_RUN;
         seed_d  = seed;
         err_d   = '0;
         first_d = '0;
         pass_d  = 1'b0;
         addr_d  = '0;
         cnt_d   = '0;
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         cnt_q      <= '0;
         seed_q     <= '0;
         pass_q     <= 1'b0;
         err_q      <= '0;
         first_q    <= '0;
         led_q      <= '0;
         cmp_vld_q  <= 1'b0;
         cmp_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         cnt_q      <= cnt_d;
         seed_q     <= seed_d;
         pass_q     <= pass_d;
         err_q      <= err_d;
         first_q    <= first_d;
         led_q      <= led_d;
         cmp_vld_q  <= (state_q == S_RUN);
         cmp_addr_q <= addr_q;
      end
   end

   assign rd_en          = (state_q == S_RUN);
   assign rd_addr        = addr_q;
   assign busy           = (state_q == S_RUN) || (state_q == S_DRAIN);
   assign done           = (state_q == S_FIN);
   assign pass           = pass_q;
   assign err_count      = err_q;
   assign first_err_addr = first_q;
   assign led            = led_q;

endmodule
